vga_palette_mapper: RTL and testbench

Parametrised colour stage for the VGA pipeline. It maps a per-pixel cell-class code to 24-bit RGB through a run-time writable palette. The block also blanks during porches and blinks the cursor (SELECTED) cell on a frame-based period. It sits between the board/cell renderer and the DAC pins, clocked on the pixel clock.

---
 rtl/vga_color_pkg.sv | 30 +++
 rtl/vga_blink_timer.sv | 42 ++++
 rtl/vga_palette_mapper.sv | 96 +++++++++
 tb/tb_vga_palette_mapper.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_color_pkg.sv
// rtl/vga_color_pkg.sv - cell-class codes, RGB struct and default palette for the VGA colour stage
package vga_color_pkg;

    localparam int MAR          = 0;
    localparam int D_FALLIDO    = 1;
    localparam int B_DESTRUIDO  = 2;
    localparam int D_ACERTADO   = 3;
    localparam int SELECTED     = 4;
    localparam int NO_ACTIVO    = 5;
    localparam int LINEAS       = 6;
    localparam int BARCO_ACTIVO = 7;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t DEFAULT_PALETTE [8] = '{
        rgb_t'(24'h3D68FF),
        rgb_t'(24'hFF0000),
        rgb_t'(24'h000000),
        rgb_t'(24'h65F929),
        rgb_t'(24'hE9F933),
        rgb_t'(24'h000000),
        rgb_t'(24'hFFFFFF),
        rgb_t'(24'h7D4C33)
    };

endpackage

// File: rtl/vga_blink_timer.sv
// rtl/vga_blink_timer.sv - frame counter that toggles the cursor blink phase every BLINK_FRAMES ticks
module vga_blink_timer #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_tick,
    output logic blink_phase
);

    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    // A held-high frame_tick counts once per cycle; no edge detection.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (frame_tick) begin
            if (cnt_q == CW'(BLINK_FRAMES - 1)) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign blink_phase = phase_q;

endmodule

// File: rtl/vga_palette_mapper.sv
// rtl/vga_palette_mapper.sv - class code to RGB via writable palette, porch blanking, cursor blink (VGA_BLINK_EN)
module vga_palette_mapper #(
    parameter int COLOR_W      = 8,
    parameter int SEL_W        = 3,
    parameter int BLINK_FRAMES = 30,
    parameter int SEL_IDX      = 4,
    parameter int ALT_IDX      = 0
) (
    input  logic                   clkVGA,
    input  logic                   rst,
    input  logic [SEL_W-1:0]       selector,
    input  logic                   video_on,
    input  logic                   frame_tick,
    input  logic                   pal_we,
    input  logic [SEL_W-1:0]       pal_addr,
    input  logic [3*COLOR_W-1:0]   pal_wdata,
    output logic [COLOR_W-1:0]     r,
    output logic [COLOR_W-1:0]     g,
    output logic [COLOR_W-1:0]     b,
    output logic                   blink_phase
);

    import vga_color_pkg::*;

    localparam int DEPTH = 2 ** SEL_W;
    localparam int PIX_W = 3 * COLOR_W;

    // Top COLOR_W bits of {c, zeros}: MSBs when narrower, left-justified when wider.
    function automatic logic [COLOR_W-1:0] scale_chan(input logic [7:0] c);
        logic [COLOR_W+7:0] ext;
        ext = {c, {COLOR_W{1'b0}}};
        return ext[COLOR_W+7 -: COLOR_W];
    endfunction

    function automatic logic [PIX_W-1:0] default_entry(input int i);
        rgb_t e;
        e = (i < 8) ? DEFAULT_PALETTE[i[2:0]] : '0;
        return {scale_chan(e.r), scale_chan(e.g), scale_chan(e.b)};
    endfunction

    logic [PIX_W-1:0] pal_q [DEPTH];
    logic [PIX_W-1:0] pal_d [DEPTH];
    logic [PIX_W-1:0] rgb_q, rgb_d;
    logic [SEL_W-1:0] look_addr;
    logic             phase_w;

`ifdef VGA_BLINK_EN
    vga_blink_timer #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink_timer (
        .clk         (clkVGA),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .blink_phase (phase_w)
    );
`else
    localparam int unused_blink_frames = BLINK_FRAMES;
    logic unused_frame_tick;
    assign unused_frame_tick = frame_tick;
    assign phase_w           = 1'b0;
`endif

    always_comb begin
        pal_d = pal_q;
        if (pal_we) pal_d[pal_addr] = pal_wdata;
    end

    always_ff @(posedge clkVGA) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) pal_q[i] <= default_entry(i);
        end else begin
            pal_q <= pal_d;
        end
    end

    // Bypass compares against the post-substitution address, so an ALT write shows during the off phase.
    always_comb begin
        look_addr = selector;
        if (phase_w && (selector == SEL_W'(SEL_IDX))) look_addr = SEL_W'(ALT_IDX);
        rgb_d = '0;
        if (video_on) begin
            rgb_d = (pal_we && (pal_addr == look_addr)) ? pal_wdata : pal_q[look_addr];
        end
    end

    always_ff @(posedge clkVGA) begin
        if (rst) rgb_q <= '0;
        else     rgb_q <= rgb_d;
    end

    assign r           = rgb_q[3*COLOR_W-1 -: COLOR_W];
    assign g           = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign b           = rgb_q[COLOR_W-1   -: COLOR_W];
    assign blink_phase = phase_w;

endmodule

// File: tb/tb_vga_palette_mapper.sv
// tb/tb_vga_palette_mapper.sv - directed self-checking bench for vga_palette_mapper
module tb_vga_palette_mapper;

    logic        clk;
    logic        rst;
    logic [2:0]  selector;
    logic        video_on;
    logic        frame_tick;
    logic        pal_we;
    logic [2:0]  pal_addr;
    logic [23:0] pal_wdata;
    logic [7:0]  r, g, b;
    logic        blink_phase;

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] exp_def [8];

    vga_palette_mapper #(
        .COLOR_W      (8),
        .SEL_W        (3),
        .BLINK_FRAMES (2),
        .SEL_IDX      (4),
        .ALT_IDX      (0)
    ) dut (
        .clkVGA      (clk),
        .rst         (rst),
        .selector    (selector),
        .video_on    (video_on),
        .frame_tick  (frame_tick),
        .pal_we      (pal_we),
        .pal_addr    (pal_addr),
        .pal_wdata   (pal_wdata),
        .r           (r),
        .g           (g),
        .b           (b),
        .blink_phase (blink_phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; selector = 3'd0; video_on = 1'b1; frame_tick = 1'b0;
        pal_we = 1'b0; pal_addr = 3'd0; pal_wdata = 24'h0;
        step(); step();
        n_checks++;
        if ({r, g, b} !== 24'h000000) begin
            n_fail++; $display("FAIL reset_rgb: got %h expected 000000", {r, g, b});
        end
        n_checks++;
        if (blink_phase !== 1'b0) begin
            n_fail++; $display("FAIL reset_phase: got %b expected 0", blink_phase);
        end
        rst = 1'b0;
        step();
        n_checks++;
        if ({r, g, b} !== 24'h3D68FF) begin
            n_fail++; $display("FAIL first_pixel: got %h expected 3d68ff", {r, g, b});
        end
        n_checks++;
        if (blink_phase !== 1'b0) begin
            n_fail++; $display("FAIL first_phase: got %b expected 0", blink_phase);
        end
    endtask

    task automatic test_defaults();
        for (int i = 0; i < 8; i++) begin
            selector = 3'(i);
            step();
            n_checks++;
            if ({r, g, b} !== exp_def[i]) begin
                n_fail++; $display("FAIL default_%0d: got %h expected %h", i, {r, g, b}, exp_def[i]);
            end
        end
    endtask

    task automatic test_blanking();
        selector = 3'd6; video_on = 1'b0;
        step();
        n_checks++;
        if ({r, g, b} !== 24'h000000) begin
            n_fail++; $display("FAIL blank: got %h expected 000000", {r, g, b});
        end
        video_on = 1'b1;
        step();
        n_checks++;
        if ({r, g, b} !== 24'hFFFFFF) begin
            n_fail++; $display("FAIL unblank: got %h expected ffffff", {r, g, b});
        end
    endtask

    task automatic test_write_through();
        pal_we = 1'b1; pal_addr = 3'd3; pal_wdata = 24'h123456; selector = 3'd3;
        step();
        n_checks++;
        if ({r, g, b} !== 24'h123456) begin
            n_fail++; $display("FAIL bypass: got %h expected 123456", {r, g, b});
        end
        pal_we = 1'b0;
        step();
        n_checks++;
        if ({r, g, b} !== 24'h123456) begin
            n_fail++; $display("FAIL persist: got %h expected 123456", {r, g, b});
        end
        pal_we = 1'b1; pal_addr = 3'd7; pal_wdata = 24'hABCDEF; selector = 3'd2;
        step();
        n_checks++;
        if ({r, g, b} !== 24'h000000) begin
            n_fail++; $display("FAIL other_addr: got %h expected 000000", {r, g, b});
        end
        pal_we = 1'b0; selector = 3'd7;
        step();
        n_checks++;
        if ({r, g, b} !== 24'hABCDEF) begin
            n_fail++; $display("FAIL written_7: got %h expected abcdef", {r, g, b});
        end
    endtask

`ifdef VGA_BLINK_EN
    task automatic test_blink();
        rst = 1'b1; step(); rst = 1'b0;
        selector = 3'd4; video_on = 1'b1;
        step();
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        step();
        n_checks++;
        if ({r, g, b} !== 24'hE9F933 || blink_phase !== 1'b0) begin
            n_fail++; $display("FAIL blink_tick1: got %h/%b expected e9f933/0", {r, g, b}, blink_phase);
        end
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        n_checks++;
        if ({r, g, b} !== 24'hE9F933 || blink_phase !== 1'b1) begin
            n_fail++; $display("FAIL blink_tick2: got %h/%b expected e9f933/1", {r, g, b}, blink_phase);
        end
        step();
        n_checks++;
        if ({r, g, b} !== 24'h3D68FF) begin
            n_fail++; $display("FAIL blink_off: got %h expected 3d68ff", {r, g, b});
        end
        pal_we = 1'b1; pal_addr = 3'd0; pal_wdata = 24'h010203;
        step();
        pal_we = 1'b0;
        n_checks++;
        if ({r, g, b} !== 24'h010203) begin
            n_fail++; $display("FAIL alt_bypass: got %h expected 010203", {r, g, b});
        end
        frame_tick = 1'b1; step(); step(); frame_tick = 1'b0;
        n_checks++;
        if ({r, g, b} !== 24'h010203 || blink_phase !== 1'b0) begin
            n_fail++; $display("FAIL blink_tick4: got %h/%b expected 010203/0", {r, g, b}, blink_phase);
        end
        step();
        n_checks++;
        if ({r, g, b} !== 24'hE9F933) begin
            n_fail++; $display("FAIL blink_on_again: got %h expected e9f933", {r, g, b});
        end
        frame_tick = 1'b1; step(); step(); step(); frame_tick = 1'b0;
        n_checks++;
        if (blink_phase !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_phase: got %b expected 1", blink_phase);
        end
        rst = 1'b1; pal_we = 1'b1; pal_addr = 3'd4; pal_wdata = 24'h111111;
        step();
        rst = 1'b0; pal_we = 1'b0;
        step();
        n_checks++;
        if ({r, g, b} !== 24'hE9F933 || blink_phase !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_blink: got %h/%b expected e9f933/0", {r, g, b}, blink_phase);
        end
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        n_checks++;
        if (blink_phase !== 1'b0) begin
            n_fail++; $display("FAIL counter_cleared: got %b expected 0", blink_phase);
        end
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        n_checks++;
        if (blink_phase !== 1'b1) begin
            n_fail++; $display("FAIL toggle_after_reset: got %b expected 1", blink_phase);
        end
    endtask
`else
    task automatic test_no_blink();
        rst = 1'b1; step(); rst = 1'b0;
        selector = 3'd4; video_on = 1'b1; frame_tick = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            n_checks++;
            if ({r, g, b} !== 24'hE9F933 || blink_phase !== 1'b0) begin
                n_fail++; $display("FAIL no_blink_%0d: got %h/%b expected e9f933/0", i, {r, g, b}, blink_phase);
            end
        end
        frame_tick = 1'b0;
    endtask
`endif

    initial begin
        exp_def[0] = 24'h3D68FF; exp_def[1] = 24'hFF0000;
        exp_def[2] = 24'h000000; exp_def[3] = 24'h65F929;
        exp_def[4] = 24'hE9F933; exp_def[5] = 24'h000000;
        exp_def[6] = 24'hFFFFFF; exp_def[7] = 24'h7D4C33;
        test_reset();
        test_defaults();
        test_blanking();
        test_write_through();
`ifdef VGA_BLINK_EN
        test_blink();
`else
        test_no_blink();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
